huff_code_gen: RTL and testbench

//  Downstream consumer of the Huffman tree memory. After merging completes, walks the

---
 rtl/huff_code_gen.sv | 185 ++++++++++++++++++
 tb/tb_huff_code_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/huff_code_gen.sv
// huff_code_gen
// Walks the merged Huffman tree from the top root down to the lowest root and
// builds one code and one length mask per leaf symbol. Each root costs two
// cycles: one to present its id to the tree memory (RD) and one to expand
// its two children (PROC). A root always has a parent with a higher id, so a
// descending sweep over the root ids sees every root's code before that
// root is expanded.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   reset     : synchronous, active-high
//   start     : begin a traversal (only honoured while idle)
//   root_sel  : node id presented to the tree memory (registered)
//   w_r       : tree memory command, tied to READ (0)
//   node_l_i  : left child of root_sel from the tree memory
//   node_r_i  : right child of root_sel from the tree memory
//   busy      : high from start acceptance through the done cycle
//   done      : one-cycle pulse, codes valid from this cycle on
//   err       : malformed tree seen, valid with done, held until next start
//   hc_flat   : code of symbol k at [k*CODE_W +: CODE_W], LSB-aligned
//   m_flat    : mask of symbol k, ones in the low len(k) bits
module huff_code_gen #(
    parameter int SYM_N  = 6,
    parameter int CODE_W = 8,
    parameter int EMPTY  = 11
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic [3:0]                root_sel,
    output logic                      w_r,
    input  logic [3:0]                node_l_i,
    input  logic [3:0]                node_r_i,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [SYM_N*CODE_W-1:0]   hc_flat,
    output logic [SYM_N*CODE_W-1:0]   m_flat
);

    localparam int TOP    = 2*SYM_N - 2;
    localparam int NROOT  = SYM_N - 1;
    localparam int RIDX_W = $clog2(NROOT);
    localparam int LIDX_W = $clog2(SYM_N);

    typedef enum logic [1:0] {IDLE, RD, PROC, DONE} state_t;

    state_t             state, state_next;
    logic [3:0]         child_l, child_r;
    logic [CODE_W-1:0]  root_code [NROOT];
    logic [CODE_W-1:0]  root_mask [NROOT];
    logic [SYM_N-1:0]   leaf_seen;

    logic [RIDX_W-1:0]  cur_idx, l_ridx, r_ridx;
    logic [LIDX_W-1:0]  l_lidx, r_lidx;
    logic [CODE_W-1:0]  code_cur, mask_cur, code_lft, code_rgt, mask_new;
    logic               l_leaf, r_leaf;
    logic               l_bad, r_bad, dup_leaf, too_long, proc_err;

    // The block only ever reads the tree memory.
    assign w_r = 1'b0;

    // Child expansion for the root currently held in root_sel. root_sel doubles
    // as the traversal cursor, so the table index is derived from it directly.
    // A root child must have a lower id than its parent; anything else (empty
    // slot, out-of-range id, cycle) is treated as a malformed tree.
    always_comb begin
        cur_idx  = RIDX_W'(root_sel - 4'(SYM_N));
        l_ridx   = RIDX_W'(child_l - 4'(SYM_N));
        r_ridx   = RIDX_W'(child_r - 4'(SYM_N));
        l_lidx   = child_l[LIDX_W-1:0];
        r_lidx   = child_r[LIDX_W-1:0];
        code_cur = root_code[cur_idx];
        mask_cur = root_mask[cur_idx];
        code_lft = {code_cur[CODE_W-2:0], 1'b0};
        code_rgt = {code_cur[CODE_W-2:0], 1'b1};
        mask_new = {mask_cur[CODE_W-2:0], 1'b1};
        l_leaf   = child_l < 4'(SYM_N);
        r_leaf   = child_r < 4'(SYM_N);
        l_bad    = (child_l == 4'(EMPTY)) || (child_l > 4'(TOP)) ||
                   (!l_leaf && (child_l >= root_sel));
        r_bad    = (child_r == 4'(EMPTY)) || (child_r > 4'(TOP)) ||
                   (!r_leaf && (child_r >= root_sel));
        dup_leaf = (l_leaf && leaf_seen[l_lidx]) ||
                   (r_leaf && leaf_seen[r_lidx]) ||
                   (l_leaf && r_leaf && (child_l == child_r));
        // The top mask bit already set means the code is CODE_W long.
        too_long = mask_cur[CODE_W-1];
        proc_err = l_bad || r_bad || dup_leaf || too_long;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and status outputs. A detected error cuts the sweep short
    // and goes straight to DONE so err is reported with the done pulse.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = RD;
            RD: begin
                busy       = 1'b1;
                state_next = PROC;
            end
            PROC: begin
                busy = 1'b1;
                if (proc_err || (root_sel == 4'(SYM_N))) state_next = DONE;
                else                                     state_next = RD;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: cursor, captured children, per-root table and leaf outputs.
    // Starting a run clears everything so stale codes never leak into a new
    // result; the top root begins with an empty code.
    always_ff @(posedge clk) begin
        if (reset) begin
            root_sel  <= 4'(TOP);
            err       <= 1'b0;
            hc_flat   <= '0;
            m_flat    <= '0;
            leaf_seen <= '0;
            child_l   <= '0;
            child_r   <= '0;
            for (int i = 0; i < NROOT; i++) begin
                root_code[i] <= '0;
                root_mask[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: if (start) begin
                    root_sel  <= 4'(TOP);
                    err       <= 1'b0;
                    hc_flat   <= '0;
                    m_flat    <= '0;
                    leaf_seen <= '0;
                    for (int i = 0; i < NROOT; i++) begin
                        root_code[i] <= '0;
                        root_mask[i] <= '0;
                    end
                end
                RD: begin
                    child_l <= node_l_i;
                    child_r <= node_r_i;
                end
                PROC: begin
                    if (proc_err) begin
                        err <= 1'b1;
                    end else begin
                        if (l_leaf) begin
                            hc_flat[l_lidx*CODE_W +: CODE_W] <= code_lft;
                            m_flat[l_lidx*CODE_W +: CODE_W]  <= mask_new;
                            leaf_seen[l_lidx]                <= 1'b1;
                        end else begin
                            root_code[l_ridx] <= code_lft;
                            root_mask[l_ridx] <= mask_new;
                        end
                        if (r_leaf) begin
                            hc_flat[r_lidx*CODE_W +: CODE_W] <= code_rgt;
                            m_flat[r_lidx*CODE_W +: CODE_W]  <= mask_new;
                            leaf_seen[r_lidx]                <= 1'b1;
                        end else begin
                            root_code[r_ridx] <= code_rgt;
                            root_mask[r_ridx] <= mask_new;
                        end
                        if (root_sel != 4'(SYM_N)) root_sel <= root_sel - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_huff_code_gen.sv
// Testbench for huff_code_gen: directed tree shapes with hand-computed codes,
// error trees, mid-run reset and a held start.
module tb_huff_code_gen;

    localparam int SYM_N  = 6;
    localparam int CODE_W = 8;
    localparam int EMPTY  = 11;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [3:0]  root_sel, node_l_i, node_r_i;
    logic        w_r, busy, done, err;
    logic [SYM_N*CODE_W-1:0] hc_flat, m_flat;

    logic [3:0]  tree_l [16];
    logic [3:0]  tree_r [16];

    int total = 0;
    int bad   = 0;

    huff_code_gen #(.SYM_N(SYM_N), .CODE_W(CODE_W), .EMPTY(EMPTY)) dut (
        .clk(clk), .reset(reset), .start(start), .root_sel(root_sel), .w_r(w_r),
        .node_l_i(node_l_i), .node_r_i(node_r_i), .busy(busy), .done(done),
        .err(err), .hc_flat(hc_flat), .m_flat(m_flat)
    );

    always #5 clk = ~clk;

    // Tree memory model: children latched on the falling edge while reading.
    always @(negedge clk) begin
        if (w_r == 1'b0) begin
            node_l_i <= tree_l[root_sel];
            node_r_i <= tree_r[root_sel];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadTree(input logic [3:0] l6, r6, l7, r7, l8, r8, l9, r9, l10, r10);
        for (int i = 0; i < 16; i++) begin
            tree_l[i] = 4'(EMPTY);
            tree_r[i] = 4'(EMPTY);
        end
        tree_l[6]  = l6;  tree_r[6]  = r6;
        tree_l[7]  = l7;  tree_r[7]  = r7;
        tree_l[8]  = l8;  tree_r[8]  = r8;
        tree_l[9]  = l9;  tree_r[9]  = r9;
        tree_l[10] = l10; tree_r[10] = r10;
    endtask

    // Pulse start for one edge and count cycles until done (bounded).
    task automatic applyStimulus(output int lat);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic checkRun(input string tag, input int lat, input int exp_lat, input logic exp_err,
                            input logic [47:0] exp_hc, input logic [47:0] exp_m);
        checkOutput({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        checkOutput({tag, "_done"}, 64'(done), 64'd1);
        checkOutput({tag, "_busy_in_done"}, 64'(busy), 64'd1);
        checkOutput({tag, "_err"}, 64'(err), 64'(exp_err));
        checkOutput({tag, "_hc"}, 64'(hc_flat), 64'(exp_hc));
        checkOutput({tag, "_m"}, 64'(m_flat), 64'(exp_m));
        tick();
        checkOutput({tag, "_done_pulse"}, 64'(done), 64'd0);
        checkOutput({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int lat;
        int pulses;
        logic [3:0] last;
        logic [3:0] seq [$];

        reset = 1'b1;
        start = 1'b0;
        loadTree(4, 5, 3, 6, 2, 7, 1, 8, 0, 9);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checkOutput("rst_root_sel", 64'(root_sel), 64'd10);
        checkOutput("rst_w_r", 64'(w_r), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        checkOutput("rst_hc", 64'(hc_flat), 64'd0);
        checkOutput("rst_m", 64'(m_flat), 64'd0);

        // Chain tree.
        loadTree(4, 5, 3, 6, 2, 7, 1, 8, 0, 9);
        applyStimulus(lat);
        checkRun("chain", lat, 10, 1'b0, 48'h1F1E0E060200, 48'h1F1F0F070301);

        // Balanced tree.
        loadTree(0, 1, 2, 3, 4, 5, 6, 7, 8, 9);
        applyStimulus(lat);
        checkRun("balanced", lat, 10, 1'b0, 48'h010007060504, 48'h030307070707);

        // Empty left child of root 8: stops after root 8 expansion.
        loadTree(4, 5, 3, 6, 11, 7, 1, 8, 0, 9);
        applyStimulus(lat);
        checkRun("empty_child", lat, 6, 1'b1, 48'h000000000200, 48'h000000000301);
        repeat (3) tick();
        checkOutput("err_held", 64'(err), 64'd1);

        // Root 9 points back at root 10.
        loadTree(4, 5, 3, 6, 2, 7, 1, 10, 0, 9);
        applyStimulus(lat);
        checkRun("bad_root_child", lat, 4, 1'b1, 48'h000000000000, 48'h000000000001);

        // Reset during PROC of root 8 (cycle after edge 5).
        loadTree(4, 5, 3, 6, 2, 7, 1, 8, 0, 9);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_err", 64'(err), 64'd0);
        checkOutput("midrst_hc", 64'(hc_flat), 64'd0);
        checkOutput("midrst_m", 64'(m_flat), 64'd0);
        checkOutput("midrst_root_sel", 64'(root_sel), 64'd10);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            if (done === 1'b1) pulses++;
            tick();
        end
        checkOutput("midrst_no_done", 64'(pulses), 64'd0);
        applyStimulus(lat);
        checkRun("after_rst", lat, 10, 1'b0, 48'h1F1E0E060200, 48'h1F1F0F070301);

        // Start held high for the whole run.
        loadTree(4, 5, 3, 6, 2, 7, 1, 8, 0, 9);
        start = 1'b1;
        tick();
        seq.push_back(root_sel);
        last = root_sel;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
            if (root_sel !== last) seq.push_back(root_sel);
            last = root_sel;
        end
        pulses = (done === 1'b1) ? 1 : 0;
        start = 1'b0;
        checkOutput("held_latency", 64'(lat), 64'd10);
        checkOutput("held_hc", 64'(hc_flat), 64'h1F1E0E060200);
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        checkOutput("held_one_done", 64'(pulses), 64'd1);
        checkOutput("held_seq_len", 64'(seq.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            logic [3:0] got;
            got = (i < seq.size()) ? seq[i] : 4'hF;
            checkOutput($sformatf("held_seq_%0d", i), 64'(got), 64'(10 - i));
        end
        checkOutput("held_busy_end", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
